// File: rtl/instr_enc_writer_if.sv
// Request and instruction-memory write bus for instr_enc_writer.
// The slave modport is the encoder's view; master is the requester/memory side.
interface instr_enc_writer_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        op_id;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [31:0]       imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;

    modport master (
        output in_valid, op_id, rd, rs1, rs2, imm, mem_ack,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, op_id, rd, rs1, rs2, imm, mem_ack,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_enc_writer.sv
// Encodes one RV32I instruction per request and writes it to sequential
// instruction-memory words, flagging illegal mnemonics and unencodable immediates.
module instr_enc_writer #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    instr_enc_writer_if.slave bus,
    input  logic              flush,
    output logic              full,
    output logic [ADDR_W:0]   instr_count,
    output logic              err_illegal,
    output logic              err_imm_range
);
    typedef enum logic [1:0] {IDLE, ENC, WR} state_t;
    typedef enum logic [2:0] {F_U, F_J, F_I, F_B, F_S, F_SH, F_R, F_X} fmt_t;

    state_t             state, state_nxt;
    fmt_t               fmt;
    logic [5:0]         op_q;
    logic [4:0]         rd_q, rs1_q, rs2_q;
    logic [31:0]        imm_q, wdata_q, enc_word;
    logic signed [31:0] simm;
    logic [6:0]         opc, f7;
    logic [2:0]         f3;
    logic [ADDR_W-1:0]  ptr;
    logic               enc_illegal, enc_bad_imm, accept, wr_done;

    assign simm    = imm_q;
    assign accept  = bus.in_valid && bus.in_ready;
    assign wr_done = (state == WR) && bus.mem_ack;

    always_comb begin
        bus.in_ready  = (state == IDLE) && !full;
        bus.mem_we    = (state == WR);
        bus.mem_addr  = ptr;
        bus.mem_wdata = wdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) state <= IDLE;
        else              state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ENC;
            ENC:     state_nxt = (enc_illegal || enc_bad_imm) ? IDLE : WR;
            WR:      if (bus.mem_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Mnemonic decode: format, opcode (where the format does not fix it), func3, func7.
    always_comb begin
        fmt = F_X;
        opc = '0;
        f3  = '0;
        f7  = '0;
        case (op_q)
            6'd0:  begin fmt = F_U;  opc = 7'b0110111; end
            6'd1:  begin fmt = F_U;  opc = 7'b0010111; end
            6'd2:  begin fmt = F_J;  opc = 7'b1101111; end
            6'd3:  begin fmt = F_I;  opc = 7'b1100111; end
            6'd4:  begin fmt = F_B;  f3 = 3'b000; end
            6'd5:  begin fmt = F_B;  f3 = 3'b001; end
            6'd6:  begin fmt = F_B;  f3 = 3'b100; end
            6'd7:  begin fmt = F_B;  f3 = 3'b101; end
            6'd8:  begin fmt = F_B;  f3 = 3'b110; end
            6'd9:  begin fmt = F_B;  f3 = 3'b111; end
            6'd10: begin fmt = F_I;  opc = 7'b0000011; f3 = 3'b000; end
            6'd11: begin fmt = F_I;  opc = 7'b0000011; f3 = 3'b001; end
            6'd12: begin fmt = F_I;  opc = 7'b0000011; f3 = 3'b010; end
            6'd13: begin fmt = F_I;  opc = 7'b0000011; f3 = 3'b100; end
            6'd14: begin fmt = F_I;  opc = 7'b0000011; f3 = 3'b101; end
            6'd15: begin fmt = F_S;  f3 = 3'b000; end
            6'd16: begin fmt = F_S;  f3 = 3'b001; end
            6'd17: begin fmt = F_S;  f3 = 3'b010; end
            6'd18: begin fmt = F_I;  opc = 7'b0010011; f3 = 3'b000; end
            6'd19: begin fmt = F_I;  opc = 7'b0010011; f3 = 3'b010; end
            6'd20: begin fmt = F_I;  opc = 7'b0010011; f3 = 3'b011; end
            6'd21: begin fmt = F_I;  opc = 7'b0010011; f3 = 3'b100; end
            6'd22: begin fmt = F_I;  opc = 7'b0010011; f3 = 3'b110; end
            6'd23: begin fmt = F_I;  opc = 7'b0010011; f3 = 3'b111; end
            6'd24: begin fmt = F_SH; f3 = 3'b001; end
            6'd25: begin fmt = F_SH; f3 = 3'b101; end
            6'd26: begin fmt = F_SH; f3 = 3'b101; f7 = 7'b0100000; end
            6'd27: begin fmt = F_R;  f3 = 3'b000; end
            6'd28: begin fmt = F_R;  f3 = 3'b000; f7 = 7'b0100000; end
            6'd29: begin fmt = F_R;  f3 = 3'b001; end
            6'd30: begin fmt = F_R;  f3 = 3'b010; end
            6'd31: begin fmt = F_R;  f3 = 3'b011; end
            6'd32: begin fmt = F_R;  f3 = 3'b100; end
            6'd33: begin fmt = F_R;  f3 = 3'b101; end
            6'd34: begin fmt = F_R;  f3 = 3'b101; f7 = 7'b0100000; end
            6'd35: begin fmt = F_R;  f3 = 3'b110; end
            6'd36: begin fmt = F_R;  f3 = 3'b111; end
            default: fmt = F_X;
        endcase
    end

    always_comb begin
        enc_word    = '0;
        enc_illegal = 1'b0;
        enc_bad_imm = 1'b0;
        case (fmt)
            F_U: begin
                enc_bad_imm = (imm_q[11:0] != 12'd0);
                enc_word    = {imm_q[31:12], rd_q, opc};
            end
            F_J: begin
                enc_bad_imm = (simm < -32'sd1048576) || (simm > 32'sd1048574) || imm_q[0];
                enc_word    = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, opc};
            end
            F_I: begin
                enc_bad_imm = (simm < -32'sd2048) || (simm > 32'sd2047);
                enc_word    = {imm_q[11:0], rs1_q, f3, rd_q, opc};
            end
            F_B: begin
                enc_bad_imm = (simm < -32'sd4096) || (simm > 32'sd4094) || imm_q[0];
                enc_word    = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3,
                               imm_q[4:1], imm_q[11], 7'b1100011};
            end
            F_S: begin
                enc_bad_imm = (simm < -32'sd2048) || (simm > 32'sd2047);
                enc_word    = {imm_q[11:5], rs2_q, rs1_q, f3, imm_q[4:0], 7'b0100011};
            end
            F_SH: begin
                enc_bad_imm = (imm_q[31:5] != 27'd0);
                enc_word    = {f7, imm_q[4:0], rs1_q, f3, rd_q, 7'b0010011};
            end
            F_R:     enc_word    = {f7, rs2_q, rs1_q, f3, rd_q, 7'b0110011};
            default: enc_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q          <= '0;
            rd_q          <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            imm_q         <= '0;
            wdata_q       <= '0;
            ptr           <= '0;
            instr_count   <= '0;
            full          <= 1'b0;
            err_illegal   <= 1'b0;
            err_imm_range <= 1'b0;
        end else if (flush) begin
            ptr         <= '0;
            instr_count <= '0;
            full        <= 1'b0;
        end else begin
            if (accept) begin
                op_q  <= bus.op_id;
                rd_q  <= bus.rd;
                rs1_q <= bus.rs1;
                rs2_q <= bus.rs2;
                imm_q <= bus.imm;
            end
            if (state == ENC) begin
                if (enc_illegal)      err_illegal   <= 1'b1;
                else if (enc_bad_imm) err_imm_range <= 1'b1;
                else                  wdata_q       <= enc_word;
            end
            if (wr_done) begin
                ptr         <= ptr + 1'b1;
                instr_count <= instr_count + 1'b1;
                if (ptr == '1) full <= 1'b1;
            end
        end
    end
endmodule

// File: doc/instr_enc_writer.md
INSTR_ENC_WRITER -- requirements
Module: instr_enc_writer

Interface
REQ-001 Parameter ADDR_W, default 8, sets the instruction-memory word-address width.
REQ-002 Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted this cycle when in_valid=1.
- op_id  in  6  mnemonic index: 0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4-9 BEQ/BNE/BLT/BGE/BLTU/BGEU, 10-14 LB/LH/LW/LBU/LHU, 15-17 SB/SH/SW, 18-23 ADDI/SLTI/SLTIU/XORI/ORI/ANDI, 24-26 SLLI/SRLI/SRAI, 27-36 ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND.
- rd, rs1, rs2  in  5 each  register fields.
- imm  in  32  signed immediate; byte offset for branches/jumps; full upper value for LUI/AUIPC.
- flush  in  1  clear write pointer and full.
- mem_we  out  1  instruction-memory write request.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  encoded RV32I word.
- mem_ack  in  1  memory accepted the write.
- full  out  1  memory image full.
- instr_count  out  ADDR_W+1  words written since reset or flush.
- err_illegal  out  1  sticky: op_id>36 seen.
- err_imm_range  out  1  sticky: immediate not encodable.

Function
REQ-003 The block SHALL encode standard RV32I words: opcodes LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011; func3/func7 per the RV32I base ISA; SUB and SRA/SRAI use func7 0100000.
REQ-004 FSM states: IDLE, ENC, WR; reset state IDLE.
REQ-005 IDLE:
- in_ready = !full.
- On in_valid&&in_ready: capture all fields, go to ENC.
REQ-006 ENC, one cycle, checks and outcome:
- Illegal op_id: set err_illegal, go to IDLE.
- Immediate out of range: set err_imm_range, go to IDLE.
- Otherwise: register mem_wdata, go to WR.
- Unused fields are ignored and encoded as 0 (e.g. rs1 for LUI).
REQ-007 Immediate legality:
- I/S-type: -2048..2047.
- B-type: -4096..4094 and even.
- J-type: -1048576..1048574 and even.
- U-type: imm[11:0]=0.
- Shifts: 0..31.
REQ-008 WR: mem_we=1 with mem_addr=ptr and mem_wdata held stable until the cycle mem_ack=1. On that edge:
- ptr and instr_count increment.
- full sets when ptr wraps from 2^ADDR_W-1 to 0.
- Go to IDLE.
REQ-009 Latency: mem_we first asserts 2 cycles after the accept edge. Peak throughput is one instruction per 3 cycles with mem_ack tied high.
REQ-010 in_ready SHALL be 0 in ENC and WR, and while full=1.
REQ-011 flush (any state), next edge: ptr=0, instr_count=0, full=0, state=IDLE.
- A pending write is dropped; mem_we is 0 the next cycle.
- Sticky error flags are kept.
- flush takes priority over a simultaneous mem_ack or accept.
REQ-012 mem_ack outside WR SHALL be ignored.
REQ-013 Error flags clear only on rst.

Reset
REQ-014 On rst at a clock edge, in any state, including mid-write:
- Outputs: mem_we=0, mem_addr=0, mem_wdata=0, full=0, instr_count=0, err_illegal=0, err_imm_range=0.
- in_ready=1 the following cycle.
- State: IDLE.
- rst overrides flush and all other inputs.

Verification
REQ-015 ADDI rd=1 rs1=0 imm=5, mem_ack=1 -> mem_we 2 cycles after accept; mem_addr=0, mem_wdata=0x00500093; instr_count=1.
REQ-016 SUB rd=3 rs1=1 rs2=2 -> 0x402081B3. BEQ rs1=1 rs2=2 imm=-4 -> 0xFE208EE3 at the next address.
REQ-017 ADDI imm=2048 -> err_imm_range=1, no mem_we, ptr unchanged. op_id=40 -> err_illegal=1, no write.
REQ-018 mem_ack held low 5 cycles in WR -> mem_we, mem_addr and mem_wdata stable for all 6 cycles; in_ready=0 throughout.
REQ-019 ADDR_W=2, four writes -> full=1, instr_count=4, in_ready=0. flush -> full=0, next write goes to mem_addr=0.
REQ-020 rst asserted during WR -> mem_we=0 next cycle, all outputs at reset values, next request writes to address 0.
